sobel_mem_arbiter: RTL and testbench

SOBEL_MEM_ARBITER -- requirements
Module: sobel_mem_arbiter

---
 rtl/sobel_pkg.sv | 19 +
 rtl/access_timer.sv | 34 +++
 rtl/sobel_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_sobel_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel memory arbiter: FSM states,
// requester ids and the default wait limit.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_CFG,
        REQ_RD,
        REQ_WR
    } req_id_e;

    localparam logic [7:0] TIMEOUT_DEF = 8'd200;

endpackage

// File: rtl/access_timer.sv
// Wait-cycle counter for one memory access; roll_o flags
// the cycle in which the count would reach limit_i.
module access_timer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       roll_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign roll_o = en_i && (cnt_q == limit_i - 8'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = roll_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sobel_mem_arbiter.sv
// Three-way arbiter (cfg > rd/wr round-robin) onto one
// byte-wide memory port, with a bounded wait per access.
module sobel_mem_arbiter
    import sobel_pkg::*;
#(
    parameter int         ADDR_W  = 16,
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_req,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cfg_done,
    output logic              rd_done,
    output logic              wr_done,
    output logic [7:0]        rdata,
    output logic              timeout_err
);

    arb_state_e        state_q;
    req_id_e           win_q;
    req_id_e           win_d;
    logic              rr_wr_q;
    logic              any_req;
    logic [ADDR_W-1:0] addr_d;
    logic              tmo;

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cfg_done_q;
    logic              rd_done_q;
    logic              wr_done_q;
    logic [7:0]        rdata_q;
    logic              terr_q;

    access_timer u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (state_q == ST_IDLE),
        .en_i    ((state_q == ST_BUSY) && !mem_ready),
        .limit_i (TIMEOUT),
        .roll_o  (tmo)
    );

    // rr_wr_q set means wr wins the next rd/wr tie
    always_comb begin
        any_req = cfg_req | rd_req | wr_req;
        win_d   = REQ_WR;
        if (cfg_req) begin
            win_d = REQ_CFG;
        end else if (rd_req && wr_req) begin
            win_d = rr_wr_q ? REQ_WR : REQ_RD;
        end else if (rd_req) begin
            win_d = REQ_RD;
        end
        unique case (win_d)
            REQ_CFG: addr_d = cfg_addr;
            REQ_RD:  addr_d = rd_addr;
            default: addr_d = wr_addr;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            win_q       <= REQ_CFG;
            rr_wr_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cfg_done_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            rdata_q     <= '0;
            terr_q      <= 1'b0;
        end else begin
            cfg_done_q <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            terr_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        win_q       <= win_d;
                        mem_addr_q  <= addr_d;
                        mem_read_q  <= (win_d != REQ_WR);
                        mem_write_q <= (win_d == REQ_WR);
                        if (win_d == REQ_WR) begin
                            mem_wdata_q <= wr_data;
                            rr_wr_q     <= 1'b0;
                        end else if (win_d == REQ_RD) begin
                            rr_wr_q <= 1'b1;
                        end
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready || tmo) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cfg_done_q  <= (win_q == REQ_CFG);
                        rd_done_q   <= (win_q == REQ_RD);
                        wr_done_q   <= (win_q == REQ_WR);
                        terr_q      <= !mem_ready;
                        if (mem_ready && win_q != REQ_WR) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cfg_done    = cfg_done_q;
    assign rd_done     = rd_done_q;
    assign wr_done     = wr_done_q;
    assign rdata       = rdata_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sobel_mem_arbiter.sv
// Directed bench for sobel_mem_arbiter; outputs sampled
// 1ns after each rising edge.
module tb_sobel_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_req;
    logic [15:0] cfg_addr;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cfg_done;
    logic        rd_done;
    logic        wr_done;
    logic [7:0]  rdata;
    logic        timeout_err;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] wcnt;

    sobel_mem_arbiter #(.ADDR_W(16), .TIMEOUT(8'd200)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cfg_req     (cfg_req),
        .cfg_addr    (cfg_addr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cfg_done    (cfg_done),
        .rd_done     (rd_done),
        .wr_done     (wr_done),
        .rdata       (rdata),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b",
                   tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_rd"}, mem_read, 1'b0);
        chk1({tag, "_wr"}, mem_write, 1'b0);
        chk1({tag, "_cdone"}, cfg_done, 1'b0);
        chk1({tag, "_rdone"}, rd_done, 1'b0);
        chk1({tag, "_wdone"}, wr_done, 1'b0);
        chk1({tag, "_terr"}, timeout_err, 1'b0);
    endtask

    initial begin
        n_rst     = 1'b0;
        cfg_req   = 1'b0;
        cfg_addr  = 16'h0000;
        rd_req    = 1'b0;
        rd_addr   = 16'h0000;
        wr_req    = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 8'h00;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        #2;
        chk_quiet("rst");
        chk16("rst_addr", mem_addr, 16'h0000);
        chk8("rst_wdata", mem_wdata, 8'h00);
        chk8("rst_rdata", rdata, 8'h00);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk_quiet("idle");

        // cfg read with two wait cycles
        cfg_req   = 1'b1;
        cfg_addr  = 16'h0004;
        mem_rdata = 8'h3C;
        tick();
        chk1("cfg_b1_rd", mem_read, 1'b1);
        chk1("cfg_b1_wr", mem_write, 1'b0);
        chk16("cfg_addr", mem_addr, 16'h0004);
        tick();
        chk1("cfg_b2_rd", mem_read, 1'b1);
        tick();
        chk1("cfg_b3_rd", mem_read, 1'b1);
        chk1("cfg_b3_done", cfg_done, 1'b0);
        mem_ready = 1'b1;
        tick();
        chk1("cfg_done", cfg_done, 1'b1);
        chk1("cfg_d_rd", mem_read, 1'b0);
        chk1("cfg_d_rdone", rd_done, 1'b0);
        chk1("cfg_d_terr", timeout_err, 1'b0);
        chk8("cfg_rdata", rdata, 8'h3C);
        cfg_req   = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk_quiet("cfg_after");

        // rd/wr tie for three accesses: rd, wr, rd
        rd_req    = 1'b1;
        rd_addr   = 16'h0100;
        wr_req    = 1'b1;
        wr_addr   = 16'h0200;
        wr_data   = 8'hA5;
        mem_ready = 1'b1;
        mem_rdata = 8'h11;
        tick();
        chk1("rr1_rd", mem_read, 1'b1);
        chk1("rr1_wr", mem_write, 1'b0);
        chk16("rr1_addr", mem_addr, 16'h0100);
        tick();
        chk1("rr1_done", rd_done, 1'b1);
        chk1("rr1_wdone", wr_done, 1'b0);
        chk8("rr1_rdata", rdata, 8'h11);
        mem_rdata = 8'h22;
        tick();
        chk_quiet("rr1_idle");
        tick();
        chk1("rr2_wr", mem_write, 1'b1);
        chk1("rr2_rd", mem_read, 1'b0);
        chk16("rr2_addr", mem_addr, 16'h0200);
        chk8("rr2_wdata", mem_wdata, 8'hA5);
        tick();
        chk1("rr2_done", wr_done, 1'b1);
        chk1("rr2_rdone", rd_done, 1'b0);
        chk8("rr2_rdata", rdata, 8'h11);
        mem_rdata = 8'h33;
        tick();
        tick();
        chk1("rr3_rd", mem_read, 1'b1);
        chk16("rr3_addr", mem_addr, 16'h0100);
        tick();
        chk1("rr3_done", rd_done, 1'b1);
        chk8("rr3_rdata", rdata, 8'h33);
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();

        // all three: cfg first, then wr (rd went last)
        cfg_req   = 1'b1;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        wr_data   = 8'h5A;
        mem_rdata = 8'h44;
        tick();
        chk16("all_cfg_addr", mem_addr, 16'h0004);
        chk1("all_cfg_rd", mem_read, 1'b1);
        tick();
        chk1("all_cfg_done", cfg_done, 1'b1);
        chk8("all_cfg_rdata", rdata, 8'h44);
        cfg_req = 1'b0;
        tick();
        tick();
        chk1("all_wr", mem_write, 1'b1);
        chk16("all_wr_addr", mem_addr, 16'h0200);
        chk8("all_wr_wdata", mem_wdata, 8'h5A);
        tick();
        chk1("all_wr_done", wr_done, 1'b1);
        mem_rdata = 8'h55;
        tick();
        tick();
        chk1("all_rd", mem_read, 1'b1);
        chk16("all_rd_addr", mem_addr, 16'h0100);
        tick();
        chk1("all_rd_done", rd_done, 1'b1);
        chk8("all_rd_rdata", rdata, 8'h55);
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();

        // write timeout: exactly 200 strobe cycles
        wr_req    = 1'b1;
        wr_addr   = 16'h1234;
        wr_data   = 8'hFF;
        mem_ready = 1'b0;
        mem_rdata = 8'hEE;
        tick();
        chk16("to_addr", mem_addr, 16'h1234);
        chk8("to_wdata", mem_wdata, 8'hFF);
        wcnt = 16'd0;
        for (int i = 0; i < 300; i++) begin
            if (!mem_write) break;
            wcnt++;
            tick();
        end
        chk16("to_cycles", wcnt, 16'd200);
        chk1("to_wdone", wr_done, 1'b1);
        chk1("to_terr", timeout_err, 1'b1);
        chk8("to_rdata", rdata, 8'h55);
        wr_req = 1'b0;
        tick();
        chk_quiet("to_after");
        tick();

        // ready in the timeout cycle: ready wins
        rd_req    = 1'b1;
        rd_addr   = 16'h0A0A;
        mem_rdata = 8'h66;
        tick();
        repeat (199) tick();
        chk1("tie_rd", mem_read, 1'b1);
        chk1("tie_pre_terr", timeout_err, 1'b0);
        mem_ready = 1'b1;
        tick();
        chk1("tie_done", rd_done, 1'b1);
        chk1("tie_terr", timeout_err, 1'b0);
        chk8("tie_rdata", rdata, 8'h66);
        rd_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();

        // reset in the 3rd BUSY cycle of a read
        rd_req    = 1'b1;
        rd_addr   = 16'h0055;
        mem_rdata = 8'h99;
        tick();
        tick();
        tick();
        chk1("rst3_rd", mem_read, 1'b1);
        #2;
        n_rst  = 1'b0;
        #1;
        chk_quiet("arst");
        chk16("arst_addr", mem_addr, 16'h0000);
        chk8("arst_wdata", mem_wdata, 8'h00);
        chk8("arst_rdata", rdata, 8'h00);
        rd_req = 1'b0;
        tick();
        chk1("arst_nodone", rd_done, 1'b0);
        n_rst     = 1'b1;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 16'h0077;
        mem_ready = 1'b1;
        mem_rdata = 8'h77;
        tick();
        chk1("post_rd", mem_read, 1'b1);
        chk1("post_wr", mem_write, 1'b0);
        chk16("post_addr", mem_addr, 16'h0055);
        tick();
        chk1("post_done", rd_done, 1'b1);
        chk8("post_rdata", rdata, 8'h77);
        rd_req = 1'b0;
        wr_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
